// File: rtl/wb_burst_sram.sv
// wb_burst_sram: Wishbone slave in front of a word-addressed SRAM. It accepts
// single and incrementing bursts (linear or wrap-4/8/16), registers ack/err
// and read data, and has an independent side port with 1-cycle read latency.
//
// Bus handshake: a beat completes on a rising edge where cyc, stb and ack (or
// err) are all high. ack/err are registered and then gated by cyc & stb, so a
// master wait state (stb low) or an abort (cyc low) shows no response in the
// same cycle. A new request is only taken in IDLE, where ack and err are low.
// Within a burst the next beat's data is fetched when the current beat
// completes, which keeps ack high on every cycle the master holds stb.
module wb_burst_sram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 30,
    parameter int DEPTH      = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_WIDTH-1:0]      wishbone_adr,
    input  logic [DATA_WIDTH-1:0]      wishbone_dat_w,
    output logic [DATA_WIDTH-1:0]      wishbone_dat_r,
    input  logic [DATA_WIDTH/8-1:0]    wishbone_sel,
    input  logic                       wishbone_cyc,
    input  logic                       wishbone_stb,
    input  logic                       wishbone_we,
    input  logic [2:0]                 wishbone_cti,
    input  logic [1:0]                 wishbone_bte,
    output logic                       wishbone_ack,
    output logic                       wishbone_err,
    input  logic [$clog2(DEPTH)-1:0]   sram_adr,
    input  logic [DATA_WIDTH-1:0]      sram_dat_w,
    input  logic                       sram_we,
    output logic [DATA_WIDTH-1:0]      sram_dat_r
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int MEM_AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_SINGLE, ST_BURST} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] dat_r_q, dat_r_d;
    logic [MEM_AW-1:0]     badr_q, badr_d;   // address of the beat being acked
    logic [1:0]            bte_q, bte_d;
    logic [DATA_WIDTH-1:0] sram_dat_r_q;
    logic                  wr_en;

    logic                  cyc_stb;
    logic [MEM_AW-1:0]     adr_lo;
    logic                  in_range;
    logic                  cti_burst;
    logic                  cti_last;
    logic [MEM_AW-1:0]     badr_nxt;
    logic                  at_linear_end;

    // Next burst address: only the low bits selected by bte roll over.
    function automatic logic [MEM_AW-1:0] wrap_inc(input logic [MEM_AW-1:0] a,
                                                   input logic [1:0] mode);
        logic [MEM_AW-1:0] inc;
        logic [MEM_AW-1:0] m;
        inc = a + MEM_AW'(1);
        case (mode)
            2'b01:   m = MEM_AW'(4'h3);
            2'b10:   m = MEM_AW'(4'h7);
            2'b11:   m = MEM_AW'(4'hF);
            default: m = '1;
        endcase
        return (a & ~m) | (inc & m);
    endfunction

    assign cyc_stb       = wishbone_cyc & wishbone_stb;
    assign adr_lo        = wishbone_adr[MEM_AW-1:0];
    assign in_range      = (wishbone_adr >> MEM_AW) == '0;
    assign cti_burst     = (wishbone_cti == 3'b010);
    assign cti_last      = (wishbone_cti == 3'b111);
    assign badr_nxt      = wrap_inc(badr_q, bte_q);
    assign at_linear_end = (bte_q == 2'b00) && (badr_q == MEM_AW'(DEPTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: bursts only for cti=010 starting in range; cyc low aborts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cyc_stb) state_d = (cti_burst && in_range) ? ST_BURST : ST_SINGLE;
            end
            ST_SINGLE: state_d = ST_IDLE;
            ST_BURST: begin
                if (!wishbone_cyc)
                    state_d = ST_IDLE;
                else if (wishbone_stb && (err_q || (ack_q && cti_last)))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath logic: response flags, read data, burst address, write strobe.
    always_comb begin
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_r_d = dat_r_q;
        badr_d  = badr_q;
        bte_d   = bte_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cyc_stb) begin
                    badr_d = adr_lo;
                    bte_d  = wishbone_bte;
                    if (in_range) begin
                        ack_d   = 1'b1;
                        dat_r_d = mem[adr_lo];
                    end else begin
                        err_d   = 1'b1;
                        dat_r_d = '0;
                    end
                end
            end
            ST_SINGLE: wr_en = cyc_stb & ack_q & wishbone_we;
            ST_BURST: begin
                if (wishbone_cyc) begin
                    if (!wishbone_stb) begin
                        // Master wait state: keep the pending response armed.
                        ack_d = ack_q;
                        err_d = err_q;
                    end else if (ack_q) begin
                        wr_en = wishbone_we;
                        if (!cti_last) begin
                            if (at_linear_end) begin
                                err_d   = 1'b1;
                                dat_r_d = '0;
                            end else begin
                                ack_d   = 1'b1;
                                badr_d  = badr_nxt;
                                dat_r_d = mem[badr_nxt];
                            end
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Response and burst registers; reset clears them (memory is left alone).
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_r_q <= '0;
            badr_q  <= '0;
            bte_q   <= 2'b00;
        end else begin
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_r_q <= dat_r_d;
            badr_q  <= badr_d;
            bte_q   <= bte_d;
        end
    end

    // Memory writes: side port first, then Wishbone lanes override on a collision.
    always_ff @(posedge clk) begin
        if (sram_we) mem[sram_adr] <= sram_dat_w;
        if (wr_en && !reset) begin
            for (int b = 0; b < SEL_WIDTH; b++) begin
                if (wishbone_sel[b]) mem[badr_q][b*8 +: 8] <= wishbone_dat_w[b*8 +: 8];
            end
        end
    end

    // Side-port read, registered, returns pre-write contents.
    always_ff @(posedge clk) begin
        if (reset) sram_dat_r_q <= '0;
        else       sram_dat_r_q <= mem[sram_adr];
    end

    assign wishbone_ack   = ack_q & cyc_stb;
    assign wishbone_err   = err_q & cyc_stb;
    assign wishbone_dat_r = dat_r_q;
    assign sram_dat_r     = sram_dat_r_q;

endmodule
